// File: rtl/pc_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pc_fetch
// Brief    : Fetch-PC owner and single-outstanding instruction fetch front end
//            feeding the IF stage register. Optional macro: FETCH_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0004
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic        hold,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] instruction,
    output logic        flush,
    output logic        misaligned
`ifdef FETCH_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    typedef enum logic [2:0] {
        S_BOOT     = 3'd0,
        S_REQ      = 3'd1,
        S_WAIT     = 3'd2,
        S_HOLD_RSP = 3'd3,
        S_DRAIN    = 3'd4
    } state_t;

    localparam logic [31:0] c_nop = 32'h0000_0013;

    state_t      r_state;
    logic [31:0] r_pc_q;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_skid_data;
    logic        r_out_valid;

    logic        w_slot_free;
    logic        w_consume;
    logic        w_tgt_mis;
    logic [31:0] w_redir_pc;
    logic [31:0] w_pc_inc;

    assign w_slot_free = !r_out_valid || !hold;
    assign w_consume   = r_out_valid && !hold && !redirect;
    assign w_tgt_mis   = |redirect_target[1:0];
    assign w_redir_pc  = w_tgt_mis ? TRAP_PC : redirect_target;
    assign w_pc_inc    = r_pc_q + 32'd4;

    assign imem_req  = (r_state == S_REQ) && w_slot_free;
    assign imem_addr = r_pc_q;
    assign flush     = !r_out_valid || redirect;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state     <= S_BOOT;
            r_pc_q      <= RESET_PC;
            r_fetch_pc  <= RESET_PC;
            r_skid_data <= c_nop;
            r_out_valid <= 1'b0;
            PC          <= 32'h0000_0000;
            instruction <= c_nop;
            misaligned  <= 1'b0;
        end else begin
            misaligned <= redirect && w_tgt_mis;
            if (redirect) begin
                r_out_valid <= 1'b0;
                r_pc_q      <= w_redir_pc;
                // A fetch already granted must have its response swallowed.
                case (r_state)
                    S_WAIT:  r_state <= imem_rvalid ? S_REQ : S_DRAIN;
                    S_REQ:   r_state <= (imem_req && imem_gnt) ? S_DRAIN : S_REQ;
                    S_DRAIN: r_state <= imem_rvalid ? S_REQ : S_DRAIN;
                    default: r_state <= S_REQ;
                endcase
            end else begin
                if (w_consume) begin
                    r_out_valid <= 1'b0;
                end
                case (r_state)
                    S_BOOT: r_state <= S_REQ;
                    S_REQ: begin
                        if (imem_req && imem_gnt) begin
                            r_fetch_pc <= r_pc_q;
                            r_state    <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (imem_rvalid) begin
                            if (w_slot_free) begin
                                PC          <= r_fetch_pc;
                                instruction <= imem_rdata;
                                r_out_valid <= 1'b1;
                                r_pc_q      <= w_pc_inc;
                                r_state     <= S_REQ;
                            end else begin
                                r_skid_data <= imem_rdata;
                                r_state     <= S_HOLD_RSP;
                            end
                        end
                    end
                    S_HOLD_RSP: begin
                        if (w_slot_free) begin
                            PC          <= r_fetch_pc;
                            instruction <= r_skid_data;
                            r_out_valid <= 1'b1;
                            r_pc_q      <= w_pc_inc;
                            r_state     <= S_REQ;
                        end
                    end
                    S_DRAIN: begin
                        if (imem_rvalid) begin
                            r_state <= S_REQ;
                        end
                    end
                    default: r_state <= S_BOOT;
                endcase
            end
        end
    end

`ifdef FETCH_CNT_EN
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            fetch_count <= 32'd0;
        end else if (w_consume) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch
// Brief    : Directed self-checking bench for pc_fetch with a delay-configurable
//            memory model plus a second instance started near the wrap point.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch;

    logic        Clock;
    logic        nReset;
    logic        hold;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] PC;
    logic [31:0] instruction;
    logic        flush;
    logic        misaligned;

    logic        hold2;
    logic        redirect2;
    logic [31:0] redirect_target2;
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        imem_gnt2;
    logic        imem_rvalid2;
    logic [31:0] imem_rdata2;
    logic [31:0] PC2;
    logic [31:0] instruction2;
    logic        flush2;
    logic        misaligned2;
`ifdef FETCH_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] fetch_count2;
`endif

    int total = 0;
    int bad   = 0;

    pc_fetch u_dut (
        .Clock(Clock), .nReset(nReset), .hold(hold), .redirect(redirect),
        .redirect_target(redirect_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .PC(PC), .instruction(instruction), .flush(flush), .misaligned(misaligned)
`ifdef FETCH_CNT_EN
        , .fetch_count(fetch_count)
`endif
    );

    pc_fetch #(.RESET_PC(32'hFFFF_FFF8), .TRAP_PC(32'h0000_0004)) u_wrap (
        .Clock(Clock), .nReset(nReset), .hold(hold2), .redirect(redirect2),
        .redirect_target(redirect_target2), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_gnt(imem_gnt2), .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
        .PC(PC2), .instruction(instruction2), .flush(flush2), .misaligned(misaligned2)
`ifdef FETCH_CNT_EN
        , .fetch_count(fetch_count2)
`endif
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Memory model: grant after gnt_dly cycles of request, respond rsp_dly cycles after grant.
    int          gnt_dly;
    int          rsp_dly;
    int          req_cnt;
    int          rsp_cnt;
    logic        pend;
    logic [31:0] pend_addr;

    assign imem_gnt = imem_req && (req_cnt >= gnt_dly);

    always @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            req_cnt     <= 0;
            rsp_cnt     <= 0;
            pend        <= 1'b0;
            pend_addr   <= 32'd0;
            imem_rvalid <= 1'b0;
            imem_rdata  <= 32'd0;
        end else begin
            imem_rvalid <= 1'b0;
            req_cnt     <= (imem_req && !imem_gnt) ? req_cnt + 1 : 0;
            if (imem_gnt) begin
                pend_addr <= imem_addr;
                rsp_cnt   <= 1;
                if (rsp_dly <= 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= 32'hAAAA_0000 + imem_addr;
                    pend        <= 1'b0;
                end else begin
                    pend <= 1'b1;
                end
            end else if (pend) begin
                if (rsp_cnt + 1 >= rsp_dly) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= 32'hAAAA_0000 + pend_addr;
                    pend        <= 1'b0;
                end else begin
                    rsp_cnt <= rsp_cnt + 1;
                end
            end
        end
    end

    assign imem_gnt2 = imem_req2;

    always @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            imem_rvalid2 <= 1'b0;
            imem_rdata2  <= 32'd0;
        end else begin
            imem_rvalid2 <= imem_gnt2;
            imem_rdata2  <= 32'hAAAA_0000 + imem_addr2;
        end
    end

    task automatic do_reset(input int gd, input int rd);
        nReset          = 1'b0;
        hold            = 1'b0;
        redirect        = 1'b0;
        redirect_target = 32'd0;
        gnt_dly         = gd;
        rsp_dly         = rd;
        repeat (2) @(negedge Clock);
        nReset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(0, 1);
        nReset = 1'b0;
        @(negedge Clock);
        total++; if (PC !== 32'd0) begin bad++; $display("FAIL rst_pc: got %h want %h", PC, 32'd0); end
        total++; if (instruction !== 32'h13) begin bad++; $display("FAIL rst_instr: got %h want %h", instruction, 32'h13); end
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL rst_flush: got %b want 1", flush); end
        total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL rst_mis: got %b want 0", misaligned); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
        total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
        nReset = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL boot_req: got %b want 0", imem_req); end
        repeat (3) @(negedge Clock);
        total++; if (instruction !== 32'hAAAA_0000) begin bad++; $display("FAIL pre_arst_instr: got %h want %h", instruction, 32'hAAAA_0000); end
        #2 nReset = 1'b0;
        #1;
        total++; if (instruction !== 32'h13) begin bad++; $display("FAIL arst_instr: got %h want %h", instruction, 32'h13); end
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL arst_flush: got %b want 1", flush); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL arst_req: got %b want 0", imem_req); end
    endtask

    task automatic test_zero_wait();
        logic        ef;
        logic [31:0] ep;
        do_reset(0, 1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge Clock);
            ef = !(k >= 3 && (k % 2 == 1));
            if (k == 1) begin
                total++; if ({imem_req, imem_addr} !== {1'b1, 32'd0}) begin bad++; $display("FAIL zw_first_req: got %b/%h want 1/%h", imem_req, imem_addr, 32'd0); end
            end
            total++; if (flush !== ef) begin bad++; $display("FAIL zw_flush k=%0d: got %b want %b", k, flush, ef); end
            if (!ef) begin
                ep = 32'((k - 3) / 2 * 4);
                total++; if (PC !== ep) begin bad++; $display("FAIL zw_pc k=%0d: got %h want %h", k, PC, ep); end
                total++; if (instruction !== 32'hAAAA_0000 + ep) begin bad++; $display("FAIL zw_instr k=%0d: got %h want %h", k, instruction, 32'hAAAA_0000 + ep); end
            end
`ifdef FETCH_CNT_EN
            if (k == 8) begin
                total++; if (fetch_count !== 32'd3) begin bad++; $display("FAIL zw_count: got %0d want 3", fetch_count); end
            end
`endif
        end
    endtask

    task automatic test_gnt_delay();
        do_reset(3, 2);
        for (int k = 1; k <= 13; k++) begin
            @(negedge Clock);
            if (k >= 7 && k <= 10) begin
                total++; if ({imem_req, imem_addr} !== {1'b1, 32'd4}) begin bad++; $display("FAIL dly_req k=%0d: got %b/%h want 1/%h", k, imem_req, imem_addr, 32'd4); end
            end
            if (k == 11) begin
                total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL dly_wait_req: got %b want 0", imem_req); end
            end
            if (k == 7) begin
                total++; if ({flush, PC} !== {1'b0, 32'd0}) begin bad++; $display("FAIL dly_pc0: got %b/%h want 0/%h", flush, PC, 32'd0); end
            end
            if (k >= 8 && k <= 12) begin
                total++; if (flush !== 1'b1) begin bad++; $display("FAIL dly_flush k=%0d: got %b want 1", k, flush); end
            end
            if (k == 13) begin
                total++; if ({flush, PC, instruction} !== {1'b0, 32'd4, 32'hAAAA_0004}) begin bad++; $display("FAIL dly_pc4: got %b/%h/%h want 0/%h/%h", flush, PC, instruction, 32'd4, 32'hAAAA_0004); end
            end
        end
    endtask

    task automatic test_hold();
        int n;
        logic [31:0] ep;
        do_reset(0, 1);
        repeat (2) @(negedge Clock);
        hold = 1'b1;
        for (int k = 3; k <= 7; k++) begin
            @(negedge Clock);
            total++; if ({flush, imem_req} !== 2'b00) begin bad++; $display("FAIL hold_ctl k=%0d: got flush=%b req=%b want 0/0", k, flush, imem_req); end
            total++; if ({PC, instruction} !== {32'd0, 32'hAAAA_0000}) begin bad++; $display("FAIL hold_slot k=%0d: got %h/%h want %h/%h", k, PC, instruction, 32'd0, 32'hAAAA_0000); end
        end
        hold = 1'b0;
        n = 0;
        for (int k = 8; k <= 11; k++) begin
            @(negedge Clock);
            if (!flush) begin
                ep = 32'(4 * (n + 1));
                total++; if ({PC, instruction} !== {ep, 32'hAAAA_0000 + ep}) begin bad++; $display("FAIL hold_seq k=%0d: got %h/%h want %h/%h", k, PC, instruction, ep, 32'hAAAA_0000 + ep); end
                n++;
            end
        end
        total++; if (n !== 2) begin bad++; $display("FAIL hold_count: got %0d want 2", n); end
    endtask

    task automatic test_redirect();
        do_reset(0, 2);
        repeat (2) @(negedge Clock);
        redirect        = 1'b1;
        redirect_target = 32'h0000_0100;
        #1;
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL rd_flush: got %b want 1", flush); end
        @(negedge Clock);
        redirect = 1'b0;
        total++; if ({flush, imem_req, misaligned} !== 3'b100) begin bad++; $display("FAIL rd_drain: got %b%b%b want 100", flush, imem_req, misaligned); end
        @(negedge Clock);
        total++; if ({flush, imem_req, imem_addr} !== {2'b11, 32'h100}) begin bad++; $display("FAIL rd_req: got %b/%b/%h want 1/1/%h", flush, imem_req, imem_addr, 32'h100); end
        repeat (2) begin
            @(negedge Clock);
            total++; if (flush !== 1'b1) begin bad++; $display("FAIL rd_bubble: got %b want 1", flush); end
        end
        @(negedge Clock);
        total++; if ({flush, PC, instruction} !== {1'b0, 32'h100, 32'hAAAA_0100}) begin bad++; $display("FAIL rd_pc: got %b/%h/%h want 0/%h/%h", flush, PC, instruction, 32'h100, 32'hAAAA_0100); end
    endtask

    task automatic test_misaligned();
        int pulses;
        do_reset(0, 1);
        repeat (3) @(negedge Clock);
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL mis_pre: got %b want 0", flush); end
        redirect        = 1'b1;
        redirect_target = 32'h0000_0102;
        #1;
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL mis_flush: got %b want 1", flush); end
        @(negedge Clock);
        redirect = 1'b0;
        pulses = misaligned ? 1 : 0;
        total++; if ({misaligned, flush, imem_req} !== 3'b110) begin bad++; $display("FAIL mis_pulse: got %b%b%b want 110", misaligned, flush, imem_req); end
        @(negedge Clock);
        pulses += misaligned ? 1 : 0;
        total++; if ({imem_req, imem_addr} !== {1'b1, 32'h4}) begin bad++; $display("FAIL mis_trap_req: got %b/%h want 1/%h", imem_req, imem_addr, 32'h4); end
        repeat (2) begin
            @(negedge Clock);
            pulses += misaligned ? 1 : 0;
        end
        total++; if ({flush, PC, instruction} !== {1'b0, 32'h4, 32'hAAAA_0004}) begin bad++; $display("FAIL mis_pc: got %b/%h/%h want 0/%h/%h", flush, PC, instruction, 32'h4, 32'hAAAA_0004); end
        total++; if (pulses !== 1) begin bad++; $display("FAIL mis_once: got %0d want 1", pulses); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        logic [31:0] ep;
        int n;
        exp_pc[0] = 32'hFFFF_FFF8;
        exp_pc[1] = 32'hFFFF_FFFC;
        exp_pc[2] = 32'h0000_0000;
        do_reset(0, 1);
        n = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge Clock);
            if (k == 1) begin
                total++; if (imem_addr2 !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_first_addr: got %h want %h", imem_addr2, 32'hFFFF_FFF8); end
            end
            if (!flush2 && n < 3) begin
                ep = exp_pc[n];
                total++; if ({PC2, instruction2} !== {ep, 32'hAAAA_0000 + ep}) begin bad++; $display("FAIL wrap_pc n=%0d: got %h/%h want %h/%h", n, PC2, instruction2, ep, 32'hAAAA_0000 + ep); end
                n++;
            end
        end
        total++; if (n !== 3) begin bad++; $display("FAIL wrap_count: got %0d want 3", n); end
`ifdef FETCH_CNT_EN
        total++; if (fetch_count2 !== 32'd3) begin bad++; $display("FAIL wrap_fetch_count: got %0d want 3", fetch_count2); end
`endif
    endtask

    initial begin
        hold2            = 1'b0;
        redirect2        = 1'b0;
        redirect_target2 = 32'd0;
        test_reset();
        test_zero_wait();
        test_gnt_delay();
        test_hold();
        test_redirect();
        test_misaligned();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
